// File: rtl/gin_scan_ctrl_pkg.sv
// Shared types and constants for the GIN bus configuration sequencer.
package gin_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      SETTLE,
      DONE,
      ERR
   } gin_cfg_state_e;

   // Idle cycles tolerated on cfg_valid while shifting before flagging an error
   localparam int unsigned GIN_TIMEOUT = 255;

   typedef struct packed {
      logic cfg_ready;
      logic busy;
      logic cfg_done;
      logic cfg_err;
   } gin_flags_t;

   // Status outputs are a pure decode of the state being entered
   function automatic gin_flags_t state_flags(gin_cfg_state_e s);
      gin_flags_t f;
      f           = '0;
      f.cfg_ready = (s == SHIFT);
      f.busy      = (s == SHIFT) || (s == SETTLE);
      f.cfg_done  = (s == DONE);
      f.cfg_err   = (s == ERR);
      return f;
   endfunction

endpackage

// File: rtl/gin_scan_ctrl_timer.sv
// Loadable saturating up-counter with clear; expire_o flags the increment
// that makes the count reach MAX.
module gin_cfg_timer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned MAX   = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] ld_val_i,
   input  logic             inc_i,
   output logic             expire_o
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_q;

   // Counter register: clear beats load beats increment; holds at MAX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (ld_i) begin
         cnt_q <= (ld_val_i > MAX_V) ? MAX_V : ld_val_i;
      end else if (inc_i && (cnt_q != MAX_V)) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   // Expiry is reported on the increment that lands on MAX (or while saturated)
   always_comb begin
      expire_o = inc_i && !clr_i && !ld_i && (cnt_q >= (MAX_V - WIDTH'(1)));
   end

endmodule

// File: rtl/gin_scan_ctrl.sv
// GIN bus configuration sequencer: loads the bus ID scan chain from the
// config stream, then opens the upstream/bus-master handshake.
module gin_scan_ctrl
   import gin_pkg::*;
#(
   parameter int unsigned NUMS_SLAVE = 8,
   parameter int unsigned ID_SIZE    = 4,
   parameter int unsigned CNT_BITS   = $clog2(NUMS_SLAVE + 1),
   parameter int unsigned TIMEOUT    = GIN_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               cfg_valid,
   input  logic [ID_SIZE-1:0] cfg_id,
   output logic               cfg_ready,
   output logic               set_id,
   output logic [ID_SIZE-1:0] ID_scan_in,
   input  logic               up_valid,
   output logic               up_ready,
   output logic               bus_master_valid,
   input  logic               bus_master_ready,
   output logic               busy,
   output logic               cfg_done,
   output logic               cfg_err
);

   localparam int unsigned         TMR_BITS = $clog2(TIMEOUT + 1);
   localparam logic [CNT_BITS-1:0] LAST     = CNT_BITS'(NUMS_SLAVE - 1);

   gin_cfg_state_e      state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d, cnt_base;
   logic                set_id_q, set_id_d;
   logic [ID_SIZE-1:0]  id_q, id_d;
   gin_flags_t          flags_q;
   logic                accept;
   logic                path_open;
   logic                tmr_clr, tmr_inc, tmr_exp;

   gin_cfg_timer #(
      .WIDTH (TMR_BITS),
      .MAX   (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst),
      .clr_i    (tmr_clr),
      .ld_i     (1'b0),
      .ld_val_i ('0),
      .inc_i    (tmr_inc),
      .expire_o (tmr_exp)
   );

   // Handshake gating: open only in DONE, and shut the cycle a restart is seen
   always_comb begin
      accept           = cfg_valid && flags_q.cfg_ready;
      path_open        = (state_q == DONE) && !start;
      bus_master_valid = path_open && up_valid;
      up_ready         = path_open && bus_master_ready;
   end

   // Next-state, shift-stage and timer control
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cnt_base = cnt_q;
      set_id_d = 1'b0;
      id_d     = id_q;
      tmr_clr  = 1'b0;
      tmr_inc  = 1'b0;
      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               tmr_clr = 1'b1;
            end
         end
         SHIFT: begin
            if (accept) begin
               // a coincident start rebases the count, this ID becomes the first
               cnt_base = start ? '0 : cnt_q;
               set_id_d = 1'b1;
               id_d     = cfg_id;
               tmr_clr  = 1'b1;
               if (cnt_base == LAST) begin
                  state_d = SETTLE;
                  cnt_d   = cnt_base;
               end else begin
                  cnt_d   = cnt_base + CNT_BITS'(1);
               end
            end else if (start) begin
               cnt_d   = '0;
               tmr_clr = 1'b1;
            end else begin
               tmr_inc = 1'b1;
               if (tmr_exp) state_d = ERR;
            end
         end
         SETTLE: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               tmr_clr = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, shift stage and status outputs registered together
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         set_id_q <= 1'b0;
         id_q     <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         set_id_q <= set_id_d;
         id_q     <= id_d;
         flags_q  <= state_flags(state_d);
      end
   end

   assign cfg_ready  = flags_q.cfg_ready;
   assign busy       = flags_q.busy;
   assign cfg_done   = flags_q.cfg_done;
   assign cfg_err    = flags_q.cfg_err;
   assign set_id     = set_id_q;
   assign ID_scan_in = id_q;

endmodule

// File: tb/tb_gin_scan_ctrl.sv
// Directed bench for gin_scan_ctrl with 8 slaves, 4-bit IDs, timeout 255.
module tb_gin_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       cfg_valid;
   logic [3:0] cfg_id;
   logic       cfg_ready;
   logic       set_id;
   logic [3:0] ID_scan_in;
   logic       up_valid;
   logic       up_ready;
   logic       bus_master_valid;
   logic       bus_master_ready;
   logic       busy;
   logic       cfg_done;
   logic       cfg_err;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [3:0] exp_q[$];

   gin_scan_ctrl #(
      .NUMS_SLAVE (8),
      .ID_SIZE    (4),
      .TIMEOUT    (255)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .cfg_valid        (cfg_valid),
      .cfg_id           (cfg_id),
      .cfg_ready        (cfg_ready),
      .set_id           (set_id),
      .ID_scan_in       (ID_scan_in),
      .up_valid         (up_valid),
      .up_ready         (up_ready),
      .bus_master_valid (bus_master_valid),
      .bus_master_ready (bus_master_ready),
      .busy             (busy),
      .cfg_done         (cfg_done),
      .cfg_err          (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // advance to 1 time unit after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cfg_ready"}, 32'(cfg_ready), 0);
      check({tag, "_set_id"}, 32'(set_id), 0);
      check({tag, "_scan_in"}, 32'(ID_scan_in), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_cfg_done"}, 32'(cfg_done), 0);
      check({tag, "_cfg_err"}, 32'(cfg_err), 0);
      check({tag, "_bmv"}, 32'(bus_master_valid), 0);
      check({tag, "_up_ready"}, 32'(up_ready), 0);
   endtask

   // Drive IDs (base+n)&15 until cfg_done; sets cycles to the loop index at
   // which cfg_done was first seen. pre/prev_in describe an accept already made.
   task automatic load_ids(input bit toggle, input int pre, input bit prev_in,
                           input int base, output int pulses, output int cycles);
      int sent;
      bit prev;
      bit acc;
      bit done;
      sent   = pre;
      prev   = prev_in;
      pulses = 0;
      cycles = -1;
      done   = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         cfg_valid = (sent < 8) && (!toggle || (c % 2 == 0));
         cfg_id    = 4'((base + sent) & 15);
         #2;
         if (cfg_done) begin
            done   = 1'b1;
            cycles = c;
         end else begin
            check("set_id_after_accept", 32'(set_id), 32'(prev));
            check("no_bmv_while_loading", 32'(bus_master_valid), 0);
            if (set_id) begin
               pulses++;
               if (exp_q.size() > 0) check("scan_in_value", 32'(ID_scan_in), 32'(exp_q.pop_front()));
            end
            acc = cfg_valid && cfg_ready;
            if (acc) begin
               exp_q.push_back(cfg_id);
               sent++;
            end
            prev = acc;
            cyc();
         end
      end
      cfg_valid = 1'b0;
      if (!done) check("load_timeout", 0, 1);
      else cyc();
   endtask

   initial begin
      int p;
      int c;
      int n;
      int hs;
      logic [4:0] rdy_pat;

      rst = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_id = '0;
      up_valid = 1'b1; bus_master_ready = 1'b1;

      // reset state, data path closed even with upstream offering
      #12;
      check_all_zero("reset");
      cyc();
      rst = 1'b1;
      cyc();
      #2;
      check("idle_bmv_gated", 32'(bus_master_valid), 0);
      check("idle_up_ready_gated", 32'(up_ready), 0);
      check("idle_cfg_ready", 32'(cfg_ready), 0);
      cyc();

      // back-to-back load of IDs 0..7
      pulse_start();
      load_ids(1'b0, 0, 1'b0, 0, p, c);
      check("b2b_pulses", 32'(p), 8);
      check("b2b_done_cycle", 32'(c + 1), 10);
      check("b2b_err", 32'(cfg_err), 0);
      check("b2b_busy", 32'(busy), 0);

      // 4-beat burst through DONE, ready dropped on beat 2
      rdy_pat = 5'b11101;   // bit i = ready in cycle i
      hs = 0;
      up_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus_master_ready = rdy_pat[i];
         #2;
         check("burst_bmv", 32'(bus_master_valid), 1);
         check("burst_up_ready", 32'(up_ready), 32'(rdy_pat[i]));
         if (up_valid && up_ready) hs++;
         cyc();
      end
      check("burst_handshakes", 32'(hs), 4);
      up_valid = 1'b0;
      #2;
      check("burst_idle_bmv", 32'(bus_master_valid), 0);
      cyc();

      // restart from DONE with upstream offering
      up_valid = 1'b1; bus_master_ready = 1'b1; start = 1'b1;
      #2;
      check("restart_up_ready", 32'(up_ready), 0);
      check("restart_bmv", 32'(bus_master_valid), 0);
      cyc();
      start = 1'b0;
      #2;
      check("restart_cfg_done", 32'(cfg_done), 0);
      check("restart_busy", 32'(busy), 1);
      check("restart_up_ready_shift", 32'(up_ready), 0);
      cyc();
      // reload with cfg_valid toggling every other cycle
      load_ids(1'b1, 0, 1'b0, 5, p, c);
      check("toggle_pulses", 32'(p), 8);
      check("toggle_done", 32'(cfg_done), 1);
      check("toggle_err", 32'(cfg_err), 0);
      up_valid = 1'b0;

      // start coincident with an accept after a partial load
      pulse_start();
      cfg_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cfg_id = 4'(i + 9);
         cyc();
      end
      start = 1'b1; cfg_id = 4'hA;
      #2;
      check("coinc_ready", 32'(cfg_ready), 1);
      exp_q.push_back(4'hA);
      cyc();
      start = 1'b0;
      load_ids(1'b0, 1, 1'b1, 3, p, c);
      check("coinc_pulses", 32'(p), 8);
      check("coinc_done", 32'(cfg_done), 1);

      // stall after 3 IDs until the timeout fires
      pulse_start();
      cfg_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cfg_id = 4'(i);
         cyc();
      end
      cfg_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 400; i++) begin
         #2;
         if (cfg_err) break;
         n++;
         cyc();
      end
      check("stall_cycles_before_err", 32'(n), 255);
      cyc();
      cfg_valid = 1'b1;
      #2;
      check("err_flag", 32'(cfg_err), 1);
      check("err_cfg_ready", 32'(cfg_ready), 0);
      check("err_busy", 32'(busy), 0);
      check("err_done", 32'(cfg_done), 0);
      cyc();
      cfg_valid = 1'b0;
      #2;
      check("err_sticky", 32'(cfg_err), 1);
      check("err_no_shift", 32'(set_id), 0);
      cyc();
      pulse_start();
      #2;
      check("err_cleared", 32'(cfg_err), 0);
      check("err_restart_busy", 32'(busy), 1);
      cyc();
      load_ids(1'b0, 0, 1'b0, 7, p, c);
      check("recover_pulses", 32'(p), 8);
      check("recover_done", 32'(cfg_done), 1);
      check("recover_err", 32'(cfg_err), 0);

      // async reset after 5 of 8 IDs
      pulse_start();
      cfg_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cfg_id = 4'(i + 1);
         cyc();
      end
      #1;
      check("pre_reset_set_id", 32'(set_id), 1);
      check("pre_reset_busy", 32'(busy), 1);
      rst = 1'b0;
      #1;
      up_valid = 1'b1;
      check_all_zero("midreset");
      cfg_valid = 1'b0;
      exp_q.delete();
      cyc();
      cyc();
      rst = 1'b1;
      up_valid = 1'b0;
      cyc();
      pulse_start();
      load_ids(1'b0, 0, 1'b0, 2, p, c);
      check("post_reset_pulses", 32'(p), 8);
      check("post_reset_done_cycle", 32'(c + 1), 10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gin_scan_ctrl.md
Name: gin_scan_ctrl

Overview:
Configuration sequencer for one GIN bus instance. Pulls a stream of slave IDs from the config source, shifts them into the bus ID scan chain via set_id/ID_scan_in, then opens the data path by gating the bus master handshake. Sits between the top-level config/data sources and the GIN bus inside the PE array; one instance per bus (X or Y).

Parameters:
NUMS_SLAVE, `NUMS_PE_COL, number of ID registers in the target scan chain
ID_SIZE, `XID_BITS, width of one ID
CNT_BITS, $clog2(NUMS_SLAVE+1), shift counter width
TIMEOUT, 255, max idle cycles waiting on cfg_valid during SHIFT before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse; begins (re)configuration
cfg_valid  in  1  config ID available
cfg_id  in  ID_SIZE  next ID; first ID accepted ends at the chain tail (slave NUMS_SLAVE-1)
cfg_ready  out  1  ID accepted this cycle when cfg_valid&cfg_ready
set_id  out  1  scan-shift enable to bus
ID_scan_in  out  ID_SIZE  scan data to chain head
up_valid  in  1  upstream data valid
up_ready  out  1  upstream ready
bus_master_valid  out  1  to bus master_valid
bus_master_ready  in  1  from bus master_ready
busy  out  1  high in SHIFT/SETTLE
cfg_done  out  1  chain loaded, data path open
cfg_err  out  1  sticky timeout flag, cleared by start

Behaviour:
- Reset (rst low, async): state IDLE; cnt=0; timer=0; set_id=0; ID_scan_in=0; cfg_ready=0; busy=0; cfg_done=0; cfg_err=0; data path closed.
- States: IDLE, SHIFT, SETTLE, DONE, ERR.
- IDLE: cfg_ready=0. start -> SHIFT; cnt=0, timer=0, cfg_done=0, cfg_err=0.
- SHIFT: cfg_ready=1. On accept: set_id=1 and ID_scan_in=cfg_id registered, driven the cycle after accept (1-cycle latency); cnt++; timer=0. No accept: set_id=0 next cycle; timer++. Accept with cnt==NUMS_SLAVE-1 -> SETTLE. timer reaching TIMEOUT -> ERR.
- set_id high exactly NUMS_SLAVE cycles per configuration, never in the same cycle as bus_master_valid.
- SETTLE: one cycle; drains the last registered shift (set_id=1 for the final ID), then -> DONE.
- DONE: cfg_done=1; bus_master_valid=up_valid; up_ready=bus_master_ready. Purely combinational pass-through in DONE only; both 0 in every other state.
- ERR: cfg_err=1, cfg_ready=0, data path closed; only start leaves (-> SHIFT).
- start during SHIFT/SETTLE: restart SHIFT with cnt=0; the partially shifted chain is overwritten by the full reload.
- start in DONE: reconfigure. Data path closes the same cycle start is seen; an upstream beat offered that cycle is not accepted (up_ready=0).
- start coincident with a cfg accept: start wins; that ID counts as the first ID of the new load.
- Async reset mid-SHIFT: all outputs go to reset values immediately; chain content undefined until the next full load.
- cnt never exceeds NUMS_SLAVE-1; timer saturates at TIMEOUT.

Decomposition:
- Package gin_pkg: state enum gin_cfg_state_e {IDLE,SHIFT,SETTLE,DONE,ERR}; TIMEOUT default constant.
- Sub-module: gin_cfg_timer (loadable saturating counter with clear/inc/expire), reused for the timeout.
- FSM, shift register stage and gating logic stay in gin_scan_ctrl.

Test Plan:
- NUMS_SLAVE=8, start, 8 back-to-back IDs 0..7 -> set_id high 8 consecutive cycles, ID_scan_in 0..7 delayed 1 cycle, cfg_done=1 at cycle 10 after start.
- Same load with cfg_valid toggling every other cycle -> set_id only on accept+1 cycles, still exactly 8 pulses, cfg_done asserts, cfg_err=0.
- Stall 255 cycles after 3 IDs -> cfg_err=1, state ERR, cfg_ready=0; then start plus 8 IDs -> cfg_err clears, cfg_done=1.
- Before cfg_done, up_valid=1, bus_master_ready=1 -> bus_master_valid=0, up_ready=0; after cfg_done, 4-beat burst with ready dropped on beat 2 -> 4 handshakes, no loss.
- start while in DONE with up_valid=1 -> up_ready=0 that cycle, cfg_done=0, busy=1, reload of 8 IDs completes.
- Assert rst low after 5 of 8 IDs -> all outputs 0 immediately; release, start, 8 IDs -> normal completion with cnt starting at 0.
